// File: rtl/iob_pfsm_loader.sv
// IOb write initiator that loads a programmable-FSM LUT image: SOFTRESET=1,
// then MEM_WORD_SELECT/MEMORY writes for every word of every entry, then SOFTRESET=0.
module iob_pfsm_loader #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int STATE_W        = 2,
  parameter int INPUT_W        = 1,
  parameter int OUTPUT_W       = 1,
  parameter int SOFTRESET_ADDR = 0,
  parameter int WORD_SEL_ADDR  = 4,
  parameter int MEMORY_ADDR    = 8
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic                          cke_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          lut_valid_i,
  input  logic [STATE_W+OUTPUT_W-1:0]   lut_data_i,
  output logic                          lut_ready_o,
  output logic                          iob_valid_o,
  output logic [ADDR_W-1:0]             iob_addr_o,
  output logic [DATA_W-1:0]             iob_wdata_o,
  output logic [(DATA_W+7)/8-1:0]       iob_wstrb_o,
  input  logic                          iob_rvalid_i,
  input  logic [DATA_W-1:0]             iob_rdata_i,
  input  logic                          iob_ready_i
);

  localparam int LUT_DATA_W = STATE_W + OUTPUT_W;
  localparam int N_WORDS    = (LUT_DATA_W + DATA_W - 1) / DATA_W;
  localparam int ENTRY_W    = INPUT_W + STATE_W;
  localparam int WORD_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int N_BYTES    = (DATA_W + 7) / 8;
  localparam int ADDR_SHIFT = $clog2(N_BYTES);
  localparam int PAD_W      = N_WORDS * DATA_W;
  localparam logic [ENTRY_W-1:0] LAST_ENTRY = {ENTRY_W{1'b1}};
  localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRST = 3'd1,
    S_GET  = 3'd2,
    S_SEL  = 3'd3,
    S_MEM  = 3'd4,
    S_SREL = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [ENTRY_W-1:0]      entry_r, entry_s;
  logic [WORD_W-1:0]       word_r, word_s;
  logic [LUT_DATA_W-1:0]   lut_r, lut_s;
  logic                    accept_s, lut_take_s, done_s, busy_s, valid_s;
  logic [ADDR_W-1:0]       addr_s;
  logic [DATA_W-1:0]       wdata_s;
  logic [PAD_W-1:0]        padded_s;
  logic                    busy_r, done_r, valid_r;
  logic [ADDR_W-1:0]       addr_r;
  logic [DATA_W-1:0]       wdata_r;
  logic [N_BYTES-1:0]      wstrb_r;
  logic                    unused_s;

  assign unused_s    = ^{iob_rvalid_i, iob_rdata_i};
  assign accept_s    = valid_r & iob_ready_i & cke_i;
  assign lut_ready_o = lut_take_s & cke_i;

  // Next-state, counter and entry-capture logic
  always_comb begin
    state_s    = state_r;
    entry_s    = entry_r;
    word_s     = word_r;
    lut_s      = lut_r;
    done_s     = 1'b0;
    lut_take_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          state_s = S_SRST;
          entry_s = '0;
          word_s  = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SRST: begin
        if (accept_s) state_s = S_GET;
        else          state_s = S_SRST;
      end
      S_GET: begin
        lut_take_s = lut_valid_i;
        if (lut_valid_i) begin
          lut_s   = lut_data_i;
          word_s  = '0;
          state_s = S_SEL;
        end else begin
          state_s = S_GET;
        end
      end
      S_SEL: begin
        if (accept_s) state_s = S_MEM;
        else          state_s = S_SEL;
      end
      S_MEM: begin
        // Terminal checks happen before any increment so the entry counter never wraps
        if (!accept_s) begin
          state_s = S_MEM;
        end else if (word_r != LAST_WORD) begin
          word_s  = word_r + 1'b1;
          state_s = S_SEL;
        end else if (entry_r != LAST_ENTRY) begin
          entry_s = entry_r + 1'b1;
          state_s = S_GET;
        end else begin
          state_s = S_SREL;
        end
      end
      S_SREL: begin
        if (accept_s) begin
          state_s = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = S_SREL;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Bus request decoded from the upcoming state so the outputs can be registered
  always_comb begin
    padded_s = PAD_W'(lut_s);
    valid_s  = 1'b0;
    addr_s   = '0;
    wdata_s  = '0;
    case (state_s)
      S_SRST: begin
        valid_s = 1'b1;
        addr_s  = ADDR_W'(SOFTRESET_ADDR);
        wdata_s = DATA_W'(1'b1);
      end
      S_SEL: begin
        valid_s = 1'b1;
        addr_s  = ADDR_W'(WORD_SEL_ADDR);
        wdata_s = DATA_W'(word_s);
      end
      S_MEM: begin
        valid_s = 1'b1;
        addr_s  = ADDR_W'(MEMORY_ADDR) + (ADDR_W'(entry_s) << ADDR_SHIFT);
        wdata_s = padded_s[int'(word_s)*DATA_W +: DATA_W];
      end
      S_SREL: begin
        valid_s = 1'b1;
        addr_s  = ADDR_W'(SOFTRESET_ADDR);
        wdata_s = '0;
      end
      default: valid_s = 1'b0;
    endcase
    busy_s = (state_s != S_IDLE) | done_s;
  end

  // State, counters and registered outputs; cke_i low freezes everything
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_r <= S_IDLE;
      entry_r <= '0;
      word_r  <= '0;
      lut_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
    end else if (cke_i) begin
      state_r <= state_s;
      entry_r <= entry_s;
      word_r  <= word_s;
      lut_r   <= lut_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      valid_r <= valid_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      wstrb_r <= valid_s ? {N_BYTES{1'b1}} : {N_BYTES{1'b0}};
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign iob_valid_o = valid_r;
  assign iob_addr_o  = addr_r;
  assign iob_wdata_o = wdata_r;
  assign iob_wstrb_o = wstrb_r;

endmodule

// File: doc/iob_pfsm_loader.md
Name: iob_pfsm_loader

Overview:
IOb-native initiator that programs a programmable-FSM peripheral's LUT over its CSR bus. It takes a full LUT image as a valid/ready stream of entries and performs the complete load sequence as bus writes: assert SOFTRESET, write MEM_WORD_SELECT and MEMORY for every word of every entry, then release SOFTRESET. It sits between a boot/config source (ROM reader, DMA, UART loader) and the peripheral's IOb slave port, so CPU-less systems can configure the FSM.

Parameters:
DATA_W, 32, IOb data width; equals the peripheral's DATA_W
ADDR_W, 16, IOb byte-address width
STATE_W, 2, FSM state width of the target
INPUT_W, 1, FSM input width of the target
OUTPUT_W, 1, FSM output width of the target
SOFTRESET_ADDR, 0, byte address of the SOFTRESET register
WORD_SEL_ADDR, 4, byte address of the MEM_WORD_SELECT register
MEMORY_ADDR, 8, byte base address of the MEMORY region
Derived: LUT_DATA_W=STATE_W+OUTPUT_W; N_WORDS=ceil(LUT_DATA_W/DATA_W); N_ENTRIES=2^(INPUT_W+STATE_W); N_BYTES=ceil(DATA_W/8)

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
cke_i  in  1  clock enable; low freezes all state
start_i  in  1  start a load (sampled in IDLE only)
busy_o  out  1  high from start acceptance until done
done_o  out  1  one-cycle pulse when the final write completes
lut_valid_i  in  1  LUT entry available
lut_data_i  in  LUT_DATA_W  entry {next_state, outputs}, entries sent in address order 0..N_ENTRIES-1
lut_ready_o  out  1  entry consumed this cycle
iob_valid_o  out  1  request valid
iob_addr_o  out  ADDR_W  byte address
iob_wdata_o  out  DATA_W  write data
iob_wstrb_o  out  N_BYTES  write strobe; always all-ones while valid
iob_rvalid_i  in  1  ignored (writes only)
iob_rdata_i  in  DATA_W  ignored
iob_ready_i  in  1  slave accepts request

Behaviour:
- Reset (arst_n_i low, async): state IDLE; all outputs 0; entry counter, word counter and entry register cleared. Reset mid-load aborts immediately, and iob_valid_o drops in the same instant; the target is left in SOFTRESET (acceptable, it is reloaded).
- Bus rule: a write completes in the cycle iob_valid_o && iob_ready_i. Address, data and strobe stay stable while valid and not ready. iob_valid_o does not drop before acceptance. There is at most one outstanding request. The next request may be presented the cycle after acceptance (no bubble required; one bubble allowed).
- FSM:
  IDLE: busy_o=0. On start_i go to SRST.
  SRST: write SOFTRESET_ADDR <= 1. On accept go to GET.
  GET: lut_ready_o=lut_valid_i. On handshake capture lut_data_i, set word=0, go to SEL.
  SEL: write WORD_SEL_ADDR <= word (zero-extended). On accept go to MEM.
  MEM: write MEMORY_ADDR + (entry << clog2(N_BYTES)) <= chunk(word). chunk(w)=entry_reg[w*DATA_W +: DATA_W], with bits above LUT_DATA_W zero-filled in the top chunk. On accept: if word<N_WORDS-1, word++ and go to SEL; else if entry<N_ENTRIES-1, entry++ and go to GET; else go to SREL.
  SREL: write SOFTRESET_ADDR <= 0. On accept go to IDLE and pulse done_o.
- busy_o=1 in every state except IDLE. start_i while busy is ignored. done_o and busy fall together.
- Total writes per load = 2 + 2*N_WORDS*N_ENTRIES, all with wstrb all-ones.
- Entry counter width is INPUT_W+STATE_W and does not wrap: the terminal check is done before increment. Address arithmetic is at ADDR_W, truncated.
- Stream stall (lut_valid_i low in GET) holds the FSM with iob_valid_o=0 indefinitely.
- cke_i low: no state or output-register change; combinational handshakes are qualified by cke_i.

Test Plan:
- Defaults (DATA_W=32, N_WORDS=1, N_ENTRIES=8), iob_ready_i tied 1, entries 0..7 = 3'h1..3'h0 → 18 writes: (0,1), then (4,0),(8+4e,entry e) for e=0..7, then (0,0); done_o pulses once, busy_o low afterwards.
- DATA_W=8, STATE_W=6, OUTPUT_W=4, INPUT_W=1, entry0=10'h2A5 → SEL 0, MEM addr 8 data 8'hA5, SEL 1, MEM addr 8 data 8'h02 (upper bits zero); 2+2*2*128=514 writes total.
- Random iob_ready_i stalls of 0-5 cycles → addr/wdata/wstrb stable while valid&&!ready; no dropped or duplicated writes versus the golden write list.
- lut_valid_i held low 20 cycles after entry 3 → no bus activity, busy_o=1; resumes with the entry-4 SEL write.
- arst_n_i pulsed during MEM of entry 5 → outputs 0 immediately, IDLE; a new start_i runs the full sequence from the SOFTRESET=1 write and entry 0.
- start_i pulsed during a load and cke_i low for 10 cycles mid-write → no restart, no state advance while cke_i is low; final sequence unchanged.
